// File: rtl/mem_port_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter.
package mem_port_arb_pkg;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_id_e;

endpackage

// File: rtl/mem_port_arb_idq.sv
// Outstanding-request source id FIFO; head names the owner of the next response.
module mem_port_arb_idq
  import mem_port_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  src_id_e                  push_id,
  input  logic                     pop,
  output src_id_e                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  src_id_e         q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= nxt(wr_ptr);
      if (pop_ok)  rd_ptr <= nxt(rd_ptr);
      if (push_ok & ~pop_ok)      count <= count + CW'(1);
      else if (~push_ok & pop_ok) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) q[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one in-order memory port between instruction fetch and load/store.
// Define MEM_PORT_ARB_RR_EN for round-robin; default is fixed LS-over-IF priority.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int OST_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_vld,
  output logic            if_req_rdy,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_rsp_vld,
  input  logic            if_rsp_rdy,
  output logic [DW-1:0]   if_rsp_data,
  input  logic            ls_req_vld,
  output logic            ls_req_rdy,
  input  logic [AW-1:0]   ls_req_addr,
  input  logic            ls_req_wr,
  input  logic [DW-1:0]   ls_req_wdata,
  input  logic [DW/8-1:0] ls_req_wstrb,
  output logic            ls_rsp_vld,
  input  logic            ls_rsp_rdy,
  output logic [DW-1:0]   ls_rsp_data,
  output logic            mem_req_vld,
  input  logic            mem_req_rdy,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_wr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  input  logic            mem_rsp_vld,
  output logic            mem_rsp_rdy,
  input  logic [DW-1:0]   mem_rsp_data
);

  localparam int CW = $clog2(OST_DEPTH) + 1;

  src_id_e         pick;
  src_id_e         win;
  src_id_e         lock_id;
  src_id_e         head;
  logic            lock_vld;
  logic            win_vld;
  logic            win_ls;
  logic            full;
  logic            empty;
  logic            req_hs;
  logic            rsp_hs;
  logic [CW-1:0]   ost_cnt;

`ifdef MEM_PORT_ARB_RR_EN
  src_id_e rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr <= SRC_IF;
    else if (req_hs) rr_ptr <= src_id_e'(~win);
  end

  always_comb begin
    pick = SRC_IF;
    unique case (1'b1)
      if_req_vld & ls_req_vld: pick = rr_ptr;
      ls_req_vld:              pick = SRC_LS;
      default:                 pick = SRC_IF;
    endcase
  end
`else
  assign pick = ls_req_vld ? SRC_LS : SRC_IF;
`endif

  // A stalled grant is held so the memory side sees a stable request.
  assign win     = lock_vld ? lock_id : pick;
  assign win_ls  = (win == SRC_LS);
  assign win_vld = win_ls ? ls_req_vld : if_req_vld;

  assign mem_req_vld = ~rst & ~full & win_vld;
  assign req_hs      = mem_req_vld & mem_req_rdy;
  assign if_req_rdy  = req_hs & ~win_ls;
  assign ls_req_rdy  = req_hs & win_ls;

  assign mem_req_addr  = win_ls ? ls_req_addr : if_req_addr;
  assign mem_req_wr    = win_ls & ls_req_wr;
  assign mem_req_wdata = win_ls ? ls_req_wdata : '0;
  assign mem_req_wstrb = win_ls ? ls_req_wstrb : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_vld <= 1'b0;
      lock_id  <= SRC_IF;
    end else if (mem_req_vld & ~mem_req_rdy) begin
      lock_vld <= 1'b1;
      lock_id  <= win;
    end else if (req_hs) begin
      lock_vld <= 1'b0;
    end
  end

  assign if_rsp_vld  = mem_rsp_vld & ~empty & (head == SRC_IF);
  assign ls_rsp_vld  = mem_rsp_vld & ~empty & (head == SRC_LS);
  assign mem_rsp_rdy = ~empty & ((head == SRC_LS) ? ls_rsp_rdy : if_rsp_rdy);
  assign rsp_hs      = mem_rsp_vld & mem_rsp_rdy;
  assign if_rsp_data = mem_rsp_data;
  assign ls_rsp_data = mem_rsp_data;

  mem_port_arb_idq #(
    .DEPTH (OST_DEPTH)
  ) u_idq (
    .clk     (clk),
    .rst     (rst),
    .push    (req_hs),
    .push_id (win),
    .pop     (rsp_hs),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (ost_cnt)
  );

  assert property (@(posedge clk) disable iff (rst)
    ost_cnt <= CW'(OST_DEPTH));

endmodule

// File: tb/tb_mem_port_arb.sv
// Randomized bench for mem_port_arb against a transaction-level model.
module tb_mem_port_arb;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int OST = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            if_req_vld, if_req_rdy, if_rsp_vld, if_rsp_rdy;
  logic [AW-1:0]   if_req_addr;
  logic [DW-1:0]   if_rsp_data;
  logic            ls_req_vld, ls_req_rdy, ls_req_wr, ls_rsp_vld, ls_rsp_rdy;
  logic [AW-1:0]   ls_req_addr;
  logic [DW-1:0]   ls_req_wdata, ls_rsp_data;
  logic [DW/8-1:0] ls_req_wstrb;
  logic            mem_req_vld, mem_req_rdy, mem_req_wr, mem_rsp_vld, mem_rsp_rdy;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata, mem_rsp_data;
  logic [DW/8-1:0] mem_req_wstrb;

  always #5 clk = ~clk;

  mem_port_arb #(.AW(AW), .DW(DW), .OST_DEPTH(OST)) dut (
    .clk(clk), .rst(rst),
    .if_req_vld(if_req_vld), .if_req_rdy(if_req_rdy), .if_req_addr(if_req_addr),
    .if_rsp_vld(if_rsp_vld), .if_rsp_rdy(if_rsp_rdy), .if_rsp_data(if_rsp_data),
    .ls_req_vld(ls_req_vld), .ls_req_rdy(ls_req_rdy), .ls_req_addr(ls_req_addr),
    .ls_req_wr(ls_req_wr), .ls_req_wdata(ls_req_wdata), .ls_req_wstrb(ls_req_wstrb),
    .ls_rsp_vld(ls_rsp_vld), .ls_rsp_rdy(ls_rsp_rdy), .ls_rsp_data(ls_rsp_data),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_req_wr(mem_req_wr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp_data(mem_rsp_data)
  );

  int errors = 0;
  int checks = 0;

  bit          if_pend, ls_pend, ls_wr_p;
  logic [31:0] if_a, ls_a, ls_wd;
  logic [3:0]  ls_ws;
  bit          ost_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] if_exp_q[$];
  logic [31:0] ls_exp_q[$];
  bit          ls_ld_q[$];
  logic [31:0] issue_log[$];
  bit          held_v, held_src, rr;
  bit          g, e_vld, req_hs, stall, rsp_hs;
  int          obs_if_n, obs_ls_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic post_if(input logic [31:0] a);
    if_pend = 1; if_a = a;
  endtask

  task automatic post_ls(input logic [31:0] a, input bit wr,
                         input logic [31:0] wd, input logic [3:0] ws);
    ls_pend = 1; ls_a = a; ls_wr_p = wr; ls_wd = wd; ls_ws = ws;
  endtask

  task automatic check_all();
    bit full, any, empty, head, dst_rdy;
    full = (ost_q.size() >= OST);
    if (held_v) begin
      g = held_src; any = 1;
    end else begin
      any = if_pend || ls_pend;
`ifdef MEM_PORT_ARB_RR_EN
      g = (if_pend && ls_pend) ? rr : ls_pend;
`else
      g = ls_pend;
`endif
    end
    e_vld = any && !full;
    chk("mem_req_vld", mem_req_vld, e_vld);
    if (e_vld) begin
      chk("mem_req_addr", mem_req_addr, g ? ls_a : if_a);
      chk("mem_req_wr", mem_req_wr, g ? ls_wr_p : 1'b0);
      chk("mem_req_wdata", mem_req_wdata, g ? ls_wd : 32'h0);
      chk("mem_req_wstrb", mem_req_wstrb, g ? ls_ws : 4'h0);
    end
    chk("if_req_rdy", if_req_rdy, e_vld && !g && mem_req_rdy);
    chk("ls_req_rdy", ls_req_rdy, e_vld && g && mem_req_rdy);
    empty   = (ost_q.size() == 0);
    head    = empty ? 1'b0 : ost_q[0];
    dst_rdy = head ? ls_rsp_rdy : if_rsp_rdy;
    chk("if_rsp_vld", if_rsp_vld, !empty && !head && mem_rsp_vld);
    chk("ls_rsp_vld", ls_rsp_vld, !empty && head && mem_rsp_vld);
    chk("mem_rsp_rdy", mem_rsp_rdy, !empty && dst_rdy);
    rsp_hs = !empty && mem_rsp_vld && dst_rdy;
    if (rsp_hs && !head) chk("if_rsp_data", if_rsp_data, if_exp_q[0]);
    if (rsp_hs && head && ls_ld_q[0]) chk("ls_rsp_data", ls_rsp_data, ls_exp_q[0]);
    req_hs = e_vld && mem_req_rdy;
    stall  = e_vld && !mem_req_rdy;
    if (if_rsp_vld && if_rsp_rdy) obs_if_n++;
    if (ls_rsp_vld && ls_rsp_rdy) obs_ls_n++;
    if (mem_req_vld && mem_req_rdy) issue_log.push_back(mem_req_addr);
  endtask

  task automatic update();
    logic [31:0] d;
    bit h;
    if (rsp_hs) begin
      h = ost_q.pop_front();
      d = mem_q.pop_front();
      if (h) begin
        d = ls_exp_q.pop_front();
        h = ls_ld_q.pop_front();
      end else begin
        d = if_exp_q.pop_front();
      end
    end
    if (req_hs) begin
      ost_q.push_back(g);
      if (g) begin
        mem_q.push_back(mem_f(ls_a));
        ls_exp_q.push_back(mem_f(ls_a));
        ls_ld_q.push_back(!ls_wr_p);
        ls_pend = 0;
      end else begin
        mem_q.push_back(mem_f(if_a));
        if_exp_q.push_back(mem_f(if_a));
        if_pend = 0;
      end
      held_v = 0;
      rr = !g;
    end else if (stall) begin
      held_v = 1;
      held_src = g;
    end
  endtask

  task automatic run_cycle(input bit mr, input bit rv, input bit ir, input bit lr);
    @(negedge clk);
    if_req_vld   = if_pend;
    if_req_addr  = if_a;
    ls_req_vld   = ls_pend;
    ls_req_addr  = ls_a;
    ls_req_wr    = ls_wr_p;
    ls_req_wdata = ls_wd;
    ls_req_wstrb = ls_ws;
    mem_req_rdy  = mr;
    if_rsp_rdy   = ir;
    ls_rsp_rdy   = lr;
    if (mem_q.size() > 0) begin
      mem_rsp_vld  = rv;
      mem_rsp_data = mem_q[0];
    end else begin
      mem_rsp_vld  = rv && ($urandom_range(3) == 0);
      mem_rsp_data = $urandom;
    end
    #1 check_all();
    @(posedge clk);
    update();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mem_req_vld"}, mem_req_vld, 0);
    chk({tag, "_if_req_rdy"}, if_req_rdy, 0);
    chk({tag, "_ls_req_rdy"}, ls_req_rdy, 0);
    chk({tag, "_mem_rsp_rdy"}, mem_rsp_rdy, 0);
    chk({tag, "_if_rsp_vld"}, if_rsp_vld, 0);
    chk({tag, "_ls_rsp_vld"}, ls_rsp_vld, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    if_req_vld = 1; ls_req_vld = 1; mem_req_rdy = 1;
    mem_rsp_vld = 1; if_rsp_rdy = 1; ls_rsp_rdy = 1;
    #1 chk_idle("rst_in");
    @(posedge clk);
    #1 chk_idle("rst_edge");
    @(negedge clk);
    rst = 0;
    if_req_vld = 0; ls_req_vld = 0; mem_rsp_vld = 0;
    ost_q.delete(); mem_q.delete(); if_exp_q.delete();
    ls_exp_q.delete(); ls_ld_q.delete();
    held_v = 0; rr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    if_req_vld = 1; if_req_addr = '0; ls_req_vld = 1; ls_req_addr = '0;
    ls_req_wr = 0; ls_req_wdata = '0; ls_req_wstrb = '0;
    mem_req_rdy = 1; mem_rsp_vld = 1; mem_rsp_data = '0;
    if_rsp_rdy = 1; ls_rsp_rdy = 1;
    @(negedge clk);
    #1 chk_idle("reset");
    @(negedge clk);
    rst = 0;
    if_req_vld = 0; ls_req_vld = 0; mem_rsp_vld = 0;

    obs_if_n = 0; obs_ls_n = 0;
    for (int k = 0; k < 3; k++) begin
      post_if(32'(k * 4));
      for (int c = 0; c < 10 && if_pend; c++) run_cycle(1, 1, 1, 1);
    end
    repeat (4) run_cycle(1, 1, 1, 1);
    chk("s1_if_rsp", obs_if_n, 3);
    chk("s1_ls_rsp", obs_ls_n, 0);

    obs_if_n = 0; obs_ls_n = 0; issue_log.delete();
    post_ls(32'h100, 0, 0, 0);
    post_if(32'h200);
    repeat (6) run_cycle(1, 1, 1, 1);
    chk("s2_issued", issue_log.size(), 2);
    if (issue_log.size() >= 2) begin
`ifdef MEM_PORT_ARB_RR_EN
      chk("s2_first", issue_log[0], 32'h200);
`else
      chk("s2_first", issue_log[0], 32'h100);
`endif
    end
    chk("s2_rsp", obs_if_n + obs_ls_n, 2);

    issue_log.delete();
    post_if(32'h10);
    post_ls(32'h20, 0, 0, 0);
    repeat (2) run_cycle(1, 0, 1, 1);
    post_if(32'h30);
    repeat (3) run_cycle(1, 0, 1, 1);
    chk("full_block", issue_log.size(), 2);
    repeat (6) run_cycle(1, 1, 1, 1);
    chk("full_drain", issue_log.size(), 3);

    issue_log.delete();
    post_ls(32'h400, 1, 32'hdead_beef, 4'hf);
    run_cycle(0, 1, 1, 1);
    post_if(32'h500);
    repeat (2) run_cycle(0, 1, 1, 1);
    chk("stall_none", issue_log.size(), 0);
    repeat (4) run_cycle(1, 1, 1, 1);
    chk("stall_n", issue_log.size(), 2);
    if (issue_log.size() >= 1) chk("stall_ls_first", issue_log[0], 32'h400);

    obs_ls_n = 0;
    post_ls(32'h600, 0, 0, 0);
    repeat (4) run_cycle(1, 1, 1, 0);
    chk("ls_hold", obs_ls_n, 0);
    do_reset();

    for (int i = 0; i < 800; i++) begin
      if (!if_pend && $urandom_range(2) == 0) post_if($urandom & 32'hffff_fffc);
      if (!ls_pend && $urandom_range(2) == 0)
        post_ls($urandom, 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)));
      run_cycle($urandom_range(3) != 0, $urandom_range(2) != 0,
                $urandom_range(3) != 0, $urandom_range(3) != 0);
      if (i == 400) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
